mat_vec_mul_ctrl: RTL and testbench

MAT_VEC_MUL_CTRL -- requirements
Module: mat_vec_mul_ctrl

---
 rtl/mvmul_pkg.sv | 27 ++
 rtl/mvmul_dot_acc.sv | 33 +++
 rtl/mat_vec_mul_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mat_vec_mul_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvmul_pkg.sv
// Shared types and defaults for the matrix-vector multiply controller.
// Holds the FSM state encoding, bus widths and default geometry.
package mvmul_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned N_DEF      = 3;
  localparam int unsigned A_BASE_DEF = 0;
  localparam int unsigned X_BASE_DEF = 9;
  localparam int unsigned Y_BASE_DEF = 12;

  typedef enum logic [2:0] {
    LDX,
    ROW,
    DRAIN,
    WR,
    FLUSH,
    DONE
  } state_t;

  // Number of two-lane read cycles needed to cover n elements.
  function automatic int unsigned pair_count(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/mvmul_dot_acc.sv
// Two-lane multiply-accumulate: adds a0*x0 (+ a1*x1 when lane 1 is live)
// into a wrapping DATA_W-bit accumulator, with a synchronous clear.
module mvmul_dot_acc
  import mvmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              lane1_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] prod0;
  logic [DATA_W-1:0] prod1;

  // Products and sum are kept at DATA_W bits so every step wraps modulo 2^DATA_W.
  assign prod0 = a0 * x0;
  assign prod1 = lane1_en ? a1 * x1 : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod0 + prod1;
  end

endmodule

// File: rtl/mat_vec_mul_ctrl.sv
// Computes y = A * x from a dual-read, single-write memory and writes y back.
// Vector x is cached first, then each row is streamed two columns per cycle.
module mat_vec_mul_ctrl
  import mvmul_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned A_BASE = A_BASE_DEF,
  parameter int unsigned X_BASE = X_BASE_DEF,
  parameter int unsigned Y_BASE = Y_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] raddr_0,
  output logic              ren_0,
  input  logic [DATA_W-1:0] rdata_0,
  output logic [ADDR_W-1:0] raddr_1,
  output logic              ren_1,
  input  logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] waddr_0,
  output logic [DATA_W-1:0] wdata_0,
  output logic              wen_0,
  output logic              valid
);

  localparam int unsigned NP    = pair_count(N);
  localparam int unsigned KW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned IW    = $clog2(N + 1);
  localparam bit          ODD_N = (N % 2) == 1;

  state_t            state, state_d;
  logic              armed;
  logic [KW-1:0]     k, k_d;
  logic [IW-1:0]     i, i_d;
  logic              flush_cnt, flush_cnt_d;
  logic              last_k;
  logic              lane1;
  logic              acc_clr;
  logic [DATA_W-1:0] acc;

  // Read-return pipeline: what the data arriving this cycle belongs to.
  logic              ld_v;
  logic              mac_v;
  logic              lane1_q;
  logic [KW-1:0]     k_q;

  // Cached vector split by lane; an odd tail leaves xv1[NP-1] at zero.
  logic [DATA_W-1:0] xv0 [NP];
  logic [DATA_W-1:0] xv1 [NP];

  assign last_k = (k == KW'(NP - 1));
  assign lane1  = !(ODD_N && last_k);

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d     = state;
    k_d         = k;
    i_d         = i;
    flush_cnt_d = flush_cnt;
    raddr_0     = '0;
    raddr_1     = '0;
    ren_0       = 1'b0;
    ren_1       = 1'b0;
    waddr_0     = '0;
    wdata_0     = '0;
    wen_0       = 1'b0;
    valid       = 1'b0;
    acc_clr     = 1'b0;

    // The first cycle after reset release only arms the controller, which
    // keeps every output at zero for as long as rst is held.
    if (armed) begin
      unique case (state)
        LDX: begin
          ren_0   = 1'b1;
          ren_1   = lane1;
          raddr_0 = ADDR_W'(X_BASE + 2 * 32'(k));
          raddr_1 = ADDR_W'(X_BASE + 2 * 32'(k) + 1);
          if (last_k) begin
            k_d     = '0;
            state_d = ROW;
          end else begin
            k_d = k + 1'b1;
          end
        end
        ROW: begin
          ren_0   = 1'b1;
          ren_1   = lane1;
          raddr_0 = ADDR_W'(A_BASE + 32'(i) * N + 2 * 32'(k));
          raddr_1 = ADDR_W'(A_BASE + 32'(i) * N + 2 * 32'(k) + 1);
          if (last_k) begin
            k_d     = '0;
            state_d = DRAIN;
          end else begin
            k_d = k + 1'b1;
          end
        end
        DRAIN: state_d = WR;
        WR: begin
          wen_0       = 1'b1;
          waddr_0     = ADDR_W'(Y_BASE + 32'(i));
          wdata_0     = acc;
          acc_clr     = 1'b1;
          i_d         = i + 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = (32'(i) + 1 < N) ? ROW : FLUSH;
        end
        FLUSH: begin
          flush_cnt_d = 1'b1;
          if (flush_cnt) state_d = DONE;
        end
        DONE:    valid = 1'b1;
        default: state_d = LDX;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LDX;
      armed     <= 1'b0;
      k         <= '0;
      i         <= '0;
      flush_cnt <= 1'b0;
      ld_v      <= 1'b0;
      mac_v     <= 1'b0;
      lane1_q   <= 1'b0;
      k_q       <= '0;
    end else begin
      state     <= state_d;
      armed     <= 1'b1;
      k         <= k_d;
      i         <= i_d;
      flush_cnt <= flush_cnt_d;
      ld_v      <= armed && (state == LDX);
      mac_v     <= armed && (state == ROW);
      lane1_q   <= lane1;
      k_q       <= k;
    end
  end

  // NOTE: the vector cache is only a few flops and must read as zero after
  // reset, so it carries a reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NP; e++) begin
        xv0[e] <= '0;
        xv1[e] <= '0;
      end
    end else if (ld_v) begin
      xv0[k_q] <= rdata_0;
      if (lane1_q) xv1[k_q] <= rdata_1;
    end
  end

  mvmul_dot_acc u_dot_acc (
    .clk      (clk),
    .rst      (rst),
    .en       (mac_v),
    .lane1_en (lane1_q),
    .clr      (acc_clr),
    .a0       (rdata_0),
    .x0       (xv0[k_q]),
    .a1       (rdata_1),
    .x1       (xv1[k_q]),
    .acc      (acc)
  );

endmodule

// File: tb/tb_mat_vec_mul_ctrl.sv
// Bench for mat_vec_mul_ctrl: an N=3 and an N=4 instance, each on its own
// memory model, with a write scoreboard filled from a reference computation.
module tb_mat_vec_mul_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3 = 1'b1;
  logic rst4 = 1'b1;
  logic load3 = 1'b0;
  logic load4 = 1'b0;
  logic sel4 = 1'b0;

  logic [31:0] d3_raddr_0, d3_raddr_1, d3_waddr_0, d3_wdata_0;
  logic [31:0] d3_rdata_0 = '0, d3_rdata_1 = '0;
  logic        d3_ren_0, d3_ren_1, d3_wen_0, d3_valid;
  logic [31:0] d4_raddr_0, d4_raddr_1, d4_waddr_0, d4_wdata_0;
  logic [31:0] d4_rdata_0 = '0, d4_rdata_1 = '0;
  logic        d4_ren_0, d4_ren_1, d4_wen_0, d4_valid;

  logic [31:0] img3 [0:31];
  logic [31:0] img4 [0:31];
  logic [31:0] mem3 [0:31];
  logic [31:0] mem4 [0:31];

  wr_t sb[$];
  int  passed = 0;
  int  total  = 0;

  mat_vec_mul_ctrl #(.N(3), .A_BASE(0), .X_BASE(9), .Y_BASE(12)) dut3 (
    .clk(clk), .rst(rst3),
    .raddr_0(d3_raddr_0), .ren_0(d3_ren_0), .rdata_0(d3_rdata_0),
    .raddr_1(d3_raddr_1), .ren_1(d3_ren_1), .rdata_1(d3_rdata_1),
    .waddr_0(d3_waddr_0), .wdata_0(d3_wdata_0), .wen_0(d3_wen_0),
    .valid(d3_valid)
  );

  mat_vec_mul_ctrl #(.N(4), .A_BASE(0), .X_BASE(16), .Y_BASE(20)) dut4 (
    .clk(clk), .rst(rst4),
    .raddr_0(d4_raddr_0), .ren_0(d4_ren_0), .rdata_0(d4_rdata_0),
    .raddr_1(d4_raddr_1), .ren_1(d4_ren_1), .rdata_1(d4_rdata_1),
    .waddr_0(d4_waddr_0), .wdata_0(d4_wdata_0), .wen_0(d4_wen_0),
    .valid(d4_valid)
  );

  // Memory models: registered reads, writes committed at the clock edge.
  always @(posedge clk) begin
    if (load3) for (int a = 0; a < 32; a++) mem3[a] <= img3[a];
    else if (d3_wen_0) mem3[d3_waddr_0[4:0]] <= d3_wdata_0;
    if (d3_ren_0) d3_rdata_0 <= mem3[d3_raddr_0[4:0]];
    if (d3_ren_1) d3_rdata_1 <= mem3[d3_raddr_1[4:0]];
  end

  always @(posedge clk) begin
    if (load4) for (int a = 0; a < 32; a++) mem4[a] <= img4[a];
    else if (d4_wen_0) mem4[d4_waddr_0[4:0]] <= d4_wdata_0;
    if (d4_ren_0) d4_rdata_0 <= mem4[d4_raddr_0[4:0]];
    if (d4_ren_1) d4_rdata_1 <= mem4[d4_raddr_1[4:0]];
  end

  logic [31:0] o_raddr_0, o_waddr_0, o_wdata_0;
  logic        o_ren_0, o_ren_1, o_wen_0, o_valid;
  assign o_raddr_0 = sel4 ? d4_raddr_0 : d3_raddr_0;
  assign o_waddr_0 = sel4 ? d4_waddr_0 : d3_waddr_0;
  assign o_wdata_0 = sel4 ? d4_wdata_0 : d3_wdata_0;
  assign o_ren_0   = sel4 ? d4_ren_0   : d3_ren_0;
  assign o_ren_1   = sel4 ? d4_ren_1   : d3_ren_1;
  assign o_wen_0   = sel4 ? d4_wen_0   : d3_wen_0;
  assign o_valid   = sel4 ? d4_valid   : d3_valid;

  task automatic load_mem(input bit use4);
    @(negedge clk);
    if (use4) load4 = 1'b1; else load3 = 1'b1;
    @(negedge clk);
    load3 = 1'b0;
    load4 = 1'b0;
  endtask

  task automatic set_basic3();
    logic [31:0] vals [0:11] = '{6, 1, 2, 3, 7, 5, 5, 2, 9, 9, 3, 7};
    for (int a = 0; a < 32; a++) img3[a] = (a < 12) ? vals[a] : 32'd0;
  endtask

  // Reference model: y[i] = sum_j A[i][j] * x[j], all 32-bit wrapping.
  task automatic push_expected(input bit use4);
    int n     = use4 ? 4 : 3;
    int xbase = use4 ? 16 : 9;
    int ybase = use4 ? 20 : 12;
    logic [31:0] s, av, xv;
    for (int r = 0; r < n; r++) begin
      s = '0;
      for (int c = 0; c < n; c++) begin
        av = use4 ? img4[r * n + c] : img3[r * n + c];
        xv = use4 ? img4[xbase + c] : img3[xbase + c];
        s  = s + av * xv;
      end
      sb.push_back('{32'(ybase + r), s});
    end
  endtask

  // Steps the selected DUT until valid, checking traffic every cycle.
  task automatic run_dut(input bit use4, input int budget,
                         output int wen_cnt, output int cyc_valid);
    int   n = use4 ? 4 : 3;
    logic exp_ren1;
    wen_cnt   = 0;
    cyc_valid = -1;
    sel4      = use4;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (o_wen_0) begin
        wen_cnt++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL stray_write: addr=%0d data=%h, none expected", o_waddr_0, o_wdata_0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          if (o_waddr_0 !== e.addr || o_wdata_0 !== e.data)
            $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                     o_waddr_0, o_wdata_0, e.addr, e.data);
          else passed++;
        end
      end
      if (o_ren_0 && o_raddr_0 < 32'(n * n)) begin
        exp_ren1 = (o_raddr_0 % n) != 32'(n - 1);
        total++;
        if (o_ren_1 !== exp_ren1)
          $display("FAIL ren_1 at raddr_0=%0d: got %b, want %b", o_raddr_0, o_ren_1, exp_ren1);
        else passed++;
      end
      if (wen_cnt < n || o_wen_0) begin
        total++;
        if (o_valid !== 1'b0)
          $display("FAIL early_valid: valid=%b after %0d writes", o_valid, wen_cnt);
        else passed++;
      end
      if (o_valid === 1'b1) begin
        cyc_valid = c;
        break;
      end
    end
  endtask

  task automatic check_done(input bit use4, input int budget, input int n,
                            input int wen_cnt, input int cyc_valid);
    total++;
    if (cyc_valid < 1 || cyc_valid > budget)
      $display("FAIL latency: valid at cycle %0d, want 1..%0d", cyc_valid, budget);
    else passed++;
    total++;
    if (wen_cnt !== n || sb.size() != 0)
      $display("FAIL write_count: got %0d writes, %0d left pending, want %0d and 0",
               wen_cnt, sb.size(), n);
    else passed++;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_ren_0, o_ren_1, o_wen_0} !== 4'b1000)
        $display("FAIL done_hold: valid/ren0/ren1/wen=%b, want 1000",
                 {o_valid, o_ren_0, o_ren_1, o_wen_0});
      else passed++;
    end
  endtask

  task automatic check_y3(input string tag, input logic [31:0] y0,
                          input logic [31:0] y1, input logic [31:0] y2);
    total++;
    if (mem3[12] !== y0 || mem3[13] !== y1 || mem3[14] !== y2)
      $display("FAIL %s: y=%h,%h,%h want %h,%h,%h", tag,
               mem3[12], mem3[13], mem3[14], y0, y1, y2);
    else passed++;
  endtask

  task automatic start3();
    rst3 = 1'b1;
    sb.delete();
    load_mem(1'b0);
    push_expected(1'b0);
    @(negedge clk);
    rst3 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({d3_raddr_0, d3_raddr_1, d3_waddr_0, d3_wdata_0,
         d3_ren_0, d3_ren_1, d3_wen_0, d3_valid} !== '0)
      $display("FAIL reset3: ren=%b%b wen=%b valid=%b raddr=%h/%h waddr=%h wdata=%h",
               d3_ren_0, d3_ren_1, d3_wen_0, d3_valid, d3_raddr_0, d3_raddr_1,
               d3_waddr_0, d3_wdata_0);
    else passed++;
    total++;
    if ({d4_raddr_0, d4_raddr_1, d4_waddr_0, d4_wdata_0,
         d4_ren_0, d4_ren_1, d4_wen_0, d4_valid} !== '0)
      $display("FAIL reset4: ren=%b%b wen=%b valid=%b", d4_ren_0, d4_ren_1, d4_wen_0, d4_valid);
    else passed++;
  endtask

  task automatic test_basic();
    int wc, cv;
    set_basic3();
    start3();
    run_dut(1'b0, 25, wc, cv);
    check_done(1'b0, 20, 3, wc, cv);
    check_y3("basic_y", 32'd71, 32'd83, 32'd114);
  endtask

  task automatic test_wrap();
    int wc, cv;
    for (int a = 0; a < 32; a++)
      img3[a] = (a < 9) ? 32'hFFFF_FFFF : (a < 12) ? 32'd2 : 32'd0;
    start3();
    run_dut(1'b0, 25, wc, cv);
    check_done(1'b0, 20, 3, wc, cv);
    check_y3("wrap_y", 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFA);
  endtask

  task automatic test_mid_reset();
    int  wc, cv;
    bit  seen = 1'b0;
    set_basic3();
    start3();
    sel4 = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (d3_wen_0) begin
        wr_t e;
        seen = 1'b1;
        e = sb.pop_front();
        total++;
        if (d3_waddr_0 !== e.addr || d3_wdata_0 !== e.data)
          $display("FAIL first_write: addr=%0d data=%h want addr=%0d data=%h",
                   d3_waddr_0, d3_wdata_0, e.addr, e.data);
        else passed++;
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL first_write: no wen_0 within 20 cycles, want one");
    end
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    total++;
    if ({d3_raddr_0, d3_raddr_1, d3_waddr_0, d3_wdata_0,
         d3_ren_0, d3_ren_1, d3_wen_0, d3_valid} !== '0)
      $display("FAIL abort_outputs: ren=%b%b wen=%b valid=%b waddr=%h wdata=%h",
               d3_ren_0, d3_ren_1, d3_wen_0, d3_valid, d3_waddr_0, d3_wdata_0);
    else passed++;
    sb.delete();
    load3 = 1'b1;
    @(negedge clk);
    load3 = 1'b0;
    total++;
    if ({d3_ren_0, d3_ren_1, d3_wen_0, d3_valid} !== 4'b0000)
      $display("FAIL abort_hold: ren=%b%b wen=%b valid=%b", d3_ren_0, d3_ren_1, d3_wen_0, d3_valid);
    else passed++;
    push_expected(1'b0);
    rst3 = 1'b0;
    run_dut(1'b0, 25, wc, cv);
    check_done(1'b0, 20, 3, wc, cv);
    check_y3("rerun_y", 32'd71, 32'd83, 32'd114);
  endtask

  task automatic test_n4_identity();
    int wc, cv;
    for (int a = 0; a < 32; a++) img4[a] = '0;
    for (int r = 0; r < 4; r++) img4[r * 4 + r] = 32'd1;
    for (int c = 0; c < 4; c++) img4[16 + c] = 32'(c + 1);
    rst4 = 1'b1;
    sb.delete();
    load_mem(1'b1);
    push_expected(1'b1);
    @(negedge clk);
    rst4 = 1'b0;
    run_dut(1'b1, 30, wc, cv);
    check_done(1'b1, 24, 4, wc, cv);
    total++;
    if (mem4[20] !== 32'd1 || mem4[21] !== 32'd2 || mem4[22] !== 32'd3 || mem4[23] !== 32'd4)
      $display("FAIL n4_y: y=%0d,%0d,%0d,%0d want 1,2,3,4",
               mem4[20], mem4[21], mem4[22], mem4[23]);
    else passed++;
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin
      img3[a] = '0;
      img4[a] = '0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_mid_reset();
    test_n4_identity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
